// File: rtl/hysteresis_reader.sv
// rtl/hysteresis_reader.sv - raster-scans the hysteresis BRAM window and streams edge-pixel coords to a FIFO.
// Optional HYST_ABS_COORD_EN: emit frame coordinates instead of reduced-window coordinates.
module hysteresis_reader #(
   parameter int WIDTH      = 1280,
   parameter int HEIGHT     = 720,
   parameter int STARTING_X = 128,
   parameter int STARTING_Y = 30,
   parameter int ENDING_X   = 1152,
   parameter int ENDING_Y   = 270,
   localparam int RW                 = ENDING_X - STARTING_X,
   localparam int RH                 = ENDING_Y - STARTING_Y,
   localparam int REDUCED_IMAGE_SIZE = RW * RH,
   localparam int AW                 = $clog2(REDUCED_IMAGE_SIZE),
   localparam int XW                 = $clog2(WIDTH),
   localparam int YW                 = $clog2(HEIGHT)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] bram_rd_addr,
   input  logic [7:0]    bram_rd_data,
   output logic          out_wr_en,
   input  logic          out_full,
   output logic [23:0]   out_din,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   scan_addr_q, scan_addr_d;
   logic [XW-1:0]   scan_x_q, scan_x_d;
   logic [YW-1:0]   scan_y_q, scan_y_d;
   logic            pend_valid_q, pend_valid_d;
   logic [AW-1:0]   pend_addr_q, pend_addr_d;
   logic [XW-1:0]   pend_x_q, pend_x_d;
   logic [YW-1:0]   pend_y_q, pend_y_d;
   logic            done_q, done_d;

   logic            pixel_hit;
   logic            stall;
   logic            issue;
   logic            last_addr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         scan_addr_q  <= '0;
         scan_x_q     <= '0;
         scan_y_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         scan_addr_q  <= scan_addr_d;
         scan_x_q     <= scan_x_d;
         scan_y_q     <= scan_y_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      pixel_hit    = pend_valid_q && (bram_rd_data != 8'd0);
      stall        = pixel_hit && out_full;
      issue        = (state_q == SCAN) && !stall;
      last_addr    = (scan_addr_q == AW'(REDUCED_IMAGE_SIZE - 1));

      out_wr_en    = pixel_hit && !out_full;
      out_din      = {3'b000, 10'(pend_y_q), 11'(pend_x_q)};
      busy         = (state_q == SCAN) || (state_q == FLUSH);
      done         = done_q;
      // A stalled pixel is re-read so its data is still present when the FIFO frees up
      bram_rd_addr = stall ? pend_addr_q : scan_addr_q;

      state_d      = state_q;
      scan_addr_d  = scan_addr_q;
      scan_x_d     = scan_x_q;
      scan_y_d     = scan_y_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (issue) begin
               if (last_addr) begin
                  state_d     = FLUSH;
                  scan_addr_d = '0;
                  scan_x_d    = '0;
                  scan_y_d    = '0;
               end else begin
                  scan_addr_d = scan_addr_q + AW'(1);
                  if (scan_x_q == XW'(RW - 1)) begin
                     scan_x_d = '0;
                     scan_y_d = scan_y_q + YW'(1);
                  end else begin
                     scan_x_d = scan_x_q + XW'(1);
                  end
               end
            end
         end
         FLUSH: begin
            if (!stall) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (stall) begin
         pend_valid_d = pend_valid_q;
         pend_addr_d  = pend_addr_q;
         pend_x_d     = pend_x_q;
         pend_y_d     = pend_y_q;
      end else begin
         pend_valid_d = issue;
         pend_addr_d  = scan_addr_q;
`ifdef HYST_ABS_COORD_EN
         pend_x_d     = scan_x_q + XW'(STARTING_X);
         pend_y_d     = scan_y_q + YW'(STARTING_Y);
`else
         pend_x_d     = scan_x_q;
         pend_y_d     = scan_y_q;
`endif
      end
   end

endmodule

// File: tb/tb_hysteresis_reader.sv
// tb/tb_hysteresis_reader.sv - directed self-checking bench for hysteresis_reader on a 4x2 window.
module tb_hysteresis_reader;

   localparam int AW = 3;
`ifdef HYST_ABS_COORD_EN
   localparam int XO = 4;
   localparam int YO = 2;
`else
   localparam int XO = 0;
   localparam int YO = 0;
`endif

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] bram_rd_addr;
   logic [7:0]    bram_rd_data;
   logic          out_wr_en;
   logic          out_full;
   logic [23:0]   out_din;
   logic          busy;
   logic          done;

   logic [7:0]    mem [8];

   int            n_cmp;
   int            n_fail;

   logic [23:0]   wr_q [$];
   int            wr_cyc [$];
   int            done_cyc [$];
   logic [31:0]   busy_tr;
   logic [31:0]   nz_tr;
   logic [AW-1:0] addr_tr [32];
   int            full_wr;

   hysteresis_reader #(
      .WIDTH(16), .HEIGHT(8), .STARTING_X(4), .STARTING_Y(2), .ENDING_X(8), .ENDING_Y(4)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
      .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
      .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) bram_rd_data <= mem[bram_rd_addr];

   function automatic logic [23:0] exp_din(input int y, input int x);
      return 24'(((y + YO) << 11) | (x + XO));
   endfunction

   task automatic fill_mem(input logic [7:0] v);
      for (int i = 0; i < 8; i++) mem[i] = v;
   endtask

   // Cycle 0 is the cycle start is high; inputs change mid-cycle, outputs sampled 1 time unit later
   task automatic run_scan(input logic [31:0] full_mask, input logic [31:0] start_mask,
                           input logic [31:0] rst_mask, input int ncyc);
      wr_q.delete();
      wr_cyc.delete();
      done_cyc.delete();
      busy_tr = '0;
      nz_tr   = '0;
      full_wr = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clock);
         start    = (k == 0) || start_mask[k];
         out_full = full_mask[k];
         reset    = rst_mask[k];
         #1;
         if (out_wr_en) begin
            wr_q.push_back(out_din);
            wr_cyc.push_back(k);
         end
         if (out_wr_en && out_full) full_wr++;
         if (done) done_cyc.push_back(k);
         busy_tr[k] = busy;
         addr_tr[k] = bram_rd_addr;
         nz_tr[k]   = out_wr_en | busy | done | (bram_rd_addr != '0) | (out_din != '0);
      end
      @(negedge clock);
      start    = 1'b0;
      out_full = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      n_cmp++; if ({bram_rd_addr, out_wr_en, out_din, busy, done} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got addr=%0d wr=%0b din=%h busy=%0b done=%0b, required all 0",
                            bram_rd_addr, out_wr_en, out_din, busy, done); end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_all_zero();
      fill_mem(8'h00);
      run_scan(32'h0, 32'h0, 32'h0, 14);
      n_cmp++; if (wr_q.size() !== 0) begin
         n_fail++; $display("FAIL zero_writes: got %0d, required 0", wr_q.size()); end
      n_cmp++; if (done_cyc.size() !== 1) begin
         n_fail++; $display("FAIL zero_done_count: got %0d, required 1", done_cyc.size()); end
      n_cmp++; if (done_cyc.size() > 0 && done_cyc[0] !== 10) begin
         n_fail++; $display("FAIL zero_done_cycle: got %0d, required 10", done_cyc[0]); end
      n_cmp++; if (busy_tr[13:0] !== 14'h03FE) begin
         n_fail++; $display("FAIL zero_busy_cycles: got %h, required 03fe", busy_tr[13:0]); end
      for (int k = 1; k <= 8; k++) begin
         n_cmp++; if (addr_tr[k] !== AW'(k - 1)) begin
            n_fail++; $display("FAIL zero_addr_c%0d: got %0d, required %0d", k, addr_tr[k], k - 1); end
      end
   endtask

   task automatic test_sparse_edges();
      logic [23:0] got;
      fill_mem(8'h00);
      mem[1] = 8'hFF;
      mem[6] = 8'h01;
      run_scan(32'h0, 32'h0, 32'h0, 12);
      n_cmp++; if (wr_q.size() !== 2) begin
         n_fail++; $display("FAIL sparse_writes: got %0d, required 2", wr_q.size()); end
      got = (wr_q.size() > 0) ? wr_q[0] : 24'hxxxxxx;
      n_cmp++; if (got !== exp_din(0, 1)) begin
         n_fail++; $display("FAIL sparse_din0: got %h, required %h", got, exp_din(0, 1)); end
      got = (wr_q.size() > 1) ? wr_q[1] : 24'hxxxxxx;
      n_cmp++; if (got !== exp_din(1, 2)) begin
         n_fail++; $display("FAIL sparse_din1: got %h, required %h", got, exp_din(1, 2)); end
      n_cmp++; if (wr_cyc.size() !== 2 || wr_cyc[0] !== 3 || wr_cyc[1] !== 8) begin
         n_fail++; $display("FAIL sparse_write_cycles: got %p, required 3 and 8", wr_cyc); end
   endtask

   task automatic test_stall();
      logic [23:0] got;
      fill_mem(8'hFF);
      run_scan(32'h0000_00F8, 32'h0, 32'h0, 18);
      n_cmp++; if (wr_q.size() !== 8) begin
         n_fail++; $display("FAIL stall_writes: got %0d, required 8", wr_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < wr_q.size()) ? wr_q[i] : 24'hxxxxxx;
         n_cmp++; if (got !== exp_din(i / 4, i % 4)) begin
            n_fail++; $display("FAIL stall_din%0d: got %h, required %h", i, got, exp_din(i / 4, i % 4)); end
      end
      for (int k = 3; k <= 7; k++) begin
         n_cmp++; if (addr_tr[k] !== AW'(1)) begin
            n_fail++; $display("FAIL stall_addr_c%0d: got %0d, required 1", k, addr_tr[k]); end
      end
      n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] !== 15) begin
         n_fail++; $display("FAIL stall_done: got %p, required single pulse at 15", done_cyc); end
      n_cmp++; if (full_wr !== 0) begin
         n_fail++; $display("FAIL stall_write_when_full: got %0d, required 0", full_wr); end
   endtask

   task automatic test_restart();
      fill_mem(8'h00);
      mem[1] = 8'hFF;
      mem[6] = 8'h01;
      run_scan(32'h0, 32'h0000_0410, 32'h0, 14);
      n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] !== 10) begin
         n_fail++; $display("FAIL restart_single_done: got %p, required single pulse at 10", done_cyc); end
      n_cmp++; if (busy_tr[11] !== 1'b0) begin
         n_fail++; $display("FAIL restart_done_cycle_start: got busy=%0b, required 0", busy_tr[11]); end
      n_cmp++; if (wr_q.size() !== 2) begin
         n_fail++; $display("FAIL restart_writes: got %0d, required 2", wr_q.size()); end
      run_scan(32'h0, 32'h0, 32'h0, 12);
      n_cmp++; if (wr_q.size() !== 2 || done_cyc.size() !== 1 || done_cyc[0] !== 10) begin
         n_fail++; $display("FAIL rescan: got writes=%0d done=%p, required 2 writes and done at 10",
                            wr_q.size(), done_cyc); end
   endtask

   task automatic test_reset_mid_scan();
      logic [23:0] got;
      fill_mem(8'hFF);
      run_scan(32'h0, 32'h0, 32'h0000_0020, 14);
      n_cmp++; if (nz_tr[13:5] !== 9'h000) begin
         n_fail++; $display("FAIL midreset_quiet: got %b, required all 0", nz_tr[13:5]); end
      n_cmp++; if (done_cyc.size() !== 0) begin
         n_fail++; $display("FAIL midreset_no_done: got %0d, required 0", done_cyc.size()); end
      n_cmp++; if (wr_q.size() !== 3) begin
         n_fail++; $display("FAIL midreset_writes: got %0d, required 3", wr_q.size()); end
      run_scan(32'h0, 32'h0, 32'h0, 12);
      got = (wr_q.size() > 0) ? wr_q[0] : 24'hxxxxxx;
      n_cmp++; if (wr_q.size() !== 8 || got !== exp_din(0, 0) || addr_tr[1] !== AW'(0)) begin
         n_fail++; $display("FAIL midreset_rescan: got writes=%0d din0=%h addr1=%0d, required 8 %h 0",
                            wr_q.size(), got, addr_tr[1], exp_din(0, 0)); end
      n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] !== 10) begin
         n_fail++; $display("FAIL midreset_rescan_done: got %p, required single pulse at 10", done_cyc); end
   endtask

   task automatic test_full_toggle();
      logic [23:0] got;
      fill_mem(8'hFF);
      run_scan(32'hAAAA_AAAA, 32'h0, 32'h0, 20);
      n_cmp++; if (full_wr !== 0) begin
         n_fail++; $display("FAIL toggle_write_when_full: got %0d, required 0", full_wr); end
      n_cmp++; if (wr_q.size() !== 8) begin
         n_fail++; $display("FAIL toggle_writes: got %0d, required 8", wr_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < wr_q.size()) ? wr_q[i] : 24'hxxxxxx;
         n_cmp++; if (got !== exp_din(i / 4, i % 4)) begin
            n_fail++; $display("FAIL toggle_din%0d: got %h, required %h", i, got, exp_din(i / 4, i % 4)); end
      end
      n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] !== 17) begin
         n_fail++; $display("FAIL toggle_done: got %p, required single pulse at 17", done_cyc); end
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      out_full = 1'b0;
      fill_mem(8'h00);
      test_reset();
      test_all_zero();
      test_sparse_edges();
      test_stall();
      test_restart();
      test_reset_mid_scan();
      test_full_toggle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
